// File: rtl/pipe_dbg_pkg.sv
// pipe_dbg_pkg: shared types, mode constants and helpers for the memory watch unit
package pipe_dbg_pkg;

    localparam logic MODE_ALL    = 1'b0;
    localparam logic MODE_CHANGE = 1'b1;

    localparam int EV_CH_W   = 2;
    localparam int EV_DATA_W = 32;
    localparam int EV_CNT_W  = 32;

    typedef struct packed {
        logic [EV_CH_W-1:0]   ch;
        logic [EV_DATA_W-1:0] data;
        logic [EV_CNT_W-1:0]  cycle;
    } ev_t;

    // ceil(log2(n)), never less than 1 so index ports stay at least one bit wide
    function automatic int CLOG2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dbg_event_fifo.sv
// dbg_event_fifo: first-word fall-through FIFO with valid/ready head and full/empty flags
module dbg_event_fifo
    import pipe_dbg_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = CLOG2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [AW:0]  wp, rp;
    logic [W-1:0] mem [DEPTH];
    logic         pop, wr;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop   = !empty && ready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign wr    = push && (!full || pop);
    assign valid = !empty;
    assign dout  = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pipe_mem_watch.sv
// pipe_mem_watch: multi-channel data-memory write watcher feeding a cycle-stamped event FIFO
module pipe_mem_watch
    import pipe_dbg_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NCH        = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32,
    parameter int CH_W       = CLOG2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic              cfg_en,
    input  logic              cfg_mode,
    input  logic [ADDR_W-1:0] cfg_addr,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [CH_W-1:0]   ev_ch,
    output logic [DATA_W-1:0] ev_data,
    output logic [CNT_W-1:0]  ev_cycle,
    output logic              overflow,
    output logic [CNT_W-1:0]  cycle
);

    localparam int EW = CH_W + DATA_W + CNT_W;

    logic [NCH-1:0]    en, mode, sv, hit, qual;
    logic [ADDR_W-1:0] addr   [NCH];
    logic [DATA_W-1:0] shadow [NCH];
    logic              push, full, empty;
    logic [CH_W-1:0]   sel;
    logic [EW-1:0]     head;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            hit[c]  = mem_we && en[c] && (mem_addr == addr[c]);
            qual[c] = hit[c] && (mode[c] == MODE_ALL || !sv[c] || mem_wdata != shadow[c]);
        end
    end

    // descending scan leaves the lowest qualifying channel selected
    always_comb begin
        push = 1'b0;
        sel  = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (qual[c]) begin
                push = 1'b1;
                sel  = CH_W'(c);
            end
        end
    end

    // config assignment comes last so a same-cycle reconfigure invalidates the shadow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en   <= '0;
            mode <= '0;
            sv   <= '0;
            for (int c = 0; c < NCH; c++) begin
                addr[c]   <= '0;
                shadow[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (hit[c]) begin
                    shadow[c] <= mem_wdata;
                    sv[c]     <= 1'b1;
                end
                if (cfg_we && cfg_ch == CH_W'(c)) begin
                    en[c]   <= cfg_en;
                    mode[c] <= cfg_mode;
                    addr[c] <= cfg_addr;
                    sv[c]   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle    <= '0;
            overflow <= 1'b0;
        end else begin
            cycle <= cycle + 1'b1;
            if (push && full && !(ev_valid && ev_ready)) overflow <= 1'b1;
        end
    end

    dbg_event_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({sel, mem_wdata, cycle}),
        .ready (ev_ready),
        .valid (ev_valid),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign {ev_ch, ev_data, ev_cycle} = head;

endmodule
